// File: rtl/flash_responder.sv
// flash_responder: fixed-latency flash read model with a preloadable store.
// Ports: clk/rst; flash_ready+flash_address request; flashData_out,
// data_valid, busy, addr_error, overrun status; load_en/addr/data preload.
module flash_responder #(
  parameter int LATENCY    = 10,
  parameter int DEPTH_BITS = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flash_ready,
  input  logic [15:0]           flash_address,
  output logic [15:0]           flashData_out,
  output logic                  data_valid,
  output logic                  busy,
  output logic                  addr_error,
  output logic                  overrun,
  input  logic                  load_en,
  input  logic [DEPTH_BITS-1:0] load_addr,
  input  logic [15:0]           load_data
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESPOND
  } state_t;

  localparam logic [3:0] LAST = 4'(LATENCY - 1);
  localparam int         WORDS = 1 << DEPTH_BITS;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] addr_q;
  logic        err_q;
  logic        capture;
  logic        fire;
  logic        in_range;

  logic [15:0] mem [0:WORDS-1];

  assign in_range = (addr_q[15:DEPTH_BITS] == '0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    capture = 1'b0;
    fire    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (flash_ready) begin
          capture = 1'b1;
          state_d = WAIT;
          cnt_d   = '0;
        end
      end
      WAIT: begin
        if (cnt_q == LAST) begin
          fire    = 1'b1;
          state_d = RESPOND;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      RESPOND: begin
        if (flash_ready) begin
          capture = 1'b1;
          state_d = WAIT;
          cnt_d   = '0;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy       = (state_q == WAIT);
  assign data_valid = (state_q == RESPOND);
  assign addr_error = data_valid & err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      addr_q        <= '0;
      err_q         <= 1'b0;
      flashData_out <= '0;
      overrun       <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (capture) begin
        addr_q <= flash_address;
      end
      // Store is read here, on the response edge, so late loads are seen.
      if (fire) begin
        err_q         <= ~in_range;
        flashData_out <= in_range ? mem[addr_q[DEPTH_BITS-1:0]] : 16'h0000;
      end
      if (busy && flash_ready) begin
        overrun <= 1'b1;
      end
    end
  end

  // No reset: contents persist across rst.
  always_ff @(posedge clk) begin
    if (load_en) begin
      mem[load_addr] <= load_data;
    end
  end

endmodule

// File: tb/tb_flash_responder.sv
// tb_flash_responder: directed checks of flash_responder, default latency
// and a LATENCY=2 instance.
module tb_flash_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        flash_ready;
  logic [15:0] flash_address;
  logic [15:0] flashData_out;
  logic        data_valid, busy, addr_error, overrun;
  logic        load_en;
  logic [5:0]  load_addr;
  logic [15:0] load_data;

  logic        fr2;
  logic [15:0] fa2;
  logic [15:0] d2;
  logic        dv2, b2, ae2, ov2;
  logic        le2;
  logic [5:0]  la2;
  logic [15:0] ld2;

  int n_asrt = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  flash_responder u_dut (
    .clk(clk), .rst(rst),
    .flash_ready(flash_ready), .flash_address(flash_address),
    .flashData_out(flashData_out), .data_valid(data_valid),
    .busy(busy), .addr_error(addr_error), .overrun(overrun),
    .load_en(load_en), .load_addr(load_addr), .load_data(load_data)
  );

  flash_responder #(.LATENCY(2)) u_l2 (
    .clk(clk), .rst(rst),
    .flash_ready(fr2), .flash_address(fa2),
    .flashData_out(d2), .data_valid(dv2),
    .busy(b2), .addr_error(ae2), .overrun(ov2),
    .load_en(le2), .load_addr(la2), .load_data(ld2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk16(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chki(input string tag, input int obs, input int exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic load(input logic [5:0] a, input logic [15:0] d);
    load_en   = 1'b1;
    load_addr = a;
    load_data = d;
    tick();
    load_en = 1'b0;
  endtask

  // Issue one request; n = edges from capture to data_valid, nb = busy
  // cycles. Optional load of ld_d to the same word on edge ld_edge.
  task automatic req(input logic [15:0] a, input int ld_edge,
                     input logic [15:0] ld_d, output int n, output int nb);
    flash_address = a;
    flash_ready   = 1'b1;
    tick();
    flash_ready = 1'b0;
    n  = 0;
    nb = busy ? 1 : 0;
    while (!data_valid && n < 40) begin
      if (n + 1 == ld_edge) begin
        load_en   = 1'b1;
        load_addr = a[5:0];
        load_data = ld_d;
      end
      tick();
      load_en = 1'b0;
      n++;
      if (busy) nb++;
    end
  endtask

  initial begin
    int n, nb, dv_edge, dv_cnt;
    logic [15:0] dv_data;
    logic [8:0]  dvv;
    logic [15:0] dat [9];

    rst = 1'b1;
    flash_ready = 1'b0; flash_address = '0;
    load_en = 1'b0; load_addr = '0; load_data = '0;
    fr2 = 1'b0; fa2 = '0; le2 = 1'b0; la2 = '0; ld2 = '0;
    dv_edge = -1; dv_cnt = 0; dv_data = '0; dvv = '0;

    repeat (2) @(posedge clk);
    #1;
    chk16("rst_data", flashData_out, 16'h0000);
    chk1("rst_dv", data_valid, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_aerr", addr_error, 1'b0);
    chk1("rst_ovr", overrun, 1'b0);
    chk1("rst_l2_dv", dv2, 1'b0);
    chk16("rst_l2_data", d2, 16'h0000);
    rst = 1'b0;
    tick();

    // Basic read, latency 10
    load(6'd5, 16'hA3C1);
    req(16'h0005, 0, 16'h0, n, nb);
    chki("lat_basic", n, 10);
    chki("busy_cycles", nb, 10);
    chk16("data_basic", flashData_out, 16'hA3C1);
    chk1("aerr_basic", addr_error, 1'b0);
    chk1("busy_at_resp", busy, 1'b0);
    tick();
    chk1("dv_one_cycle", data_valid, 1'b0);
    chk16("data_hold", flashData_out, 16'hA3C1);

    // Out of range address
    req(16'h0040, 0, 16'h0, n, nb);
    chki("lat_oor", n, 10);
    chk16("data_oor", flashData_out, 16'h0000);
    chk1("aerr_oor", addr_error, 1'b1);
    tick();
    chk1("aerr_clear", addr_error, 1'b0);
    chk1("ovr_still0", overrun, 1'b0);

    // Overrun with flash_ready held 12 cycles, incrementing address
    load(6'd3, 16'h0333);
    load(6'd14, 16'h0E0E);
    for (int i = 0; i < 12; i++) begin
      flash_address = 16'(3 + i);
      flash_ready   = 1'b1;
      tick();
      if (data_valid) begin
        dv_edge = i;
        dv_cnt++;
        dv_data = flashData_out;
      end
    end
    flash_ready = 1'b0;
    chki("ovr_dv_edge", dv_edge, 10);
    chki("ovr_dv_count", dv_cnt, 1);
    chk16("ovr_first_data", dv_data, 16'h0333);
    chk1("ovr_set", overrun, 1'b1);
    n = 0;
    while (!data_valid && n < 40) begin
      tick();
      n++;
    end
    chki("ovr_second_lat", n, 10);
    chk16("ovr_second_data", flashData_out, 16'h0E0E);
    tick();

    // Load during WAIT visible; load on response edge is read-before-write
    load(6'd7, 16'h1111);
    req(16'h0007, 4, 16'h2222, n, nb);
    chki("ldwait_lat", n, 10);
    chk16("ldwait_data", flashData_out, 16'h2222);
    tick();
    load(6'd7, 16'h1111);
    req(16'h0007, 10, 16'h2222, n, nb);
    chk16("rbw_old", flashData_out, 16'h1111);
    tick();
    req(16'h0007, 0, 16'h0, n, nb);
    chk16("rbw_new", flashData_out, 16'h2222);
    tick();

    // Reset in the middle of WAIT
    flash_address = 16'h0005;
    flash_ready   = 1'b1;
    tick();
    flash_ready = 1'b0;
    repeat (5) tick();
    chk1("pre_rst_busy", busy, 1'b1);
    rst = 1'b1;
    #2;
    chk1("mrst_busy", busy, 1'b0);
    chk1("mrst_dv", data_valid, 1'b0);
    chk16("mrst_data", flashData_out, 16'h0000);
    chk1("mrst_ovr", overrun, 1'b0);
    chk1("mrst_aerr", addr_error, 1'b0);
    tick();
    tick();
    rst = 1'b0;
    dv_cnt = 0;
    repeat (6) begin
      tick();
      if (data_valid) dv_cnt++;
    end
    chki("mrst_no_dv", dv_cnt, 0);
    req(16'h0005, 0, 16'h0, n, nb);
    chki("post_rst_lat", n, 10);
    chk16("post_rst_data", flashData_out, 16'hA3C1);
    tick();

    // LATENCY=2 instance
    le2 = 1'b1; la2 = 6'd1; ld2 = 16'hBEEF;
    tick();
    la2 = 6'd2; ld2 = 16'hCAFE;
    tick();
    le2 = 1'b0;
    fa2 = 16'h0001;
    fr2 = 1'b1;
    tick();
    fr2 = 1'b0;
    chk1("l2_busy", b2, 1'b1);
    tick();
    chk1("l2_dv_e1", dv2, 1'b0);
    tick();
    chk1("l2_dv_e2", dv2, 1'b1);
    chk16("l2_data", d2, 16'hBEEF);
    tick();
    for (int i = 0; i < 9; i++) begin
      fa2 = (i % 2 == 1) ? 16'h0002 : 16'h0001;
      fr2 = 1'b1;
      tick();
      dvv[i] = dv2;
      dat[i] = d2;
    end
    fr2 = 1'b0;
    chk16("l2_b2b_pattern", {7'd0, dvv}, {7'd0, 9'b100100100});
    chk16("l2_b2b_e2", dat[2], 16'hBEEF);
    chk16("l2_b2b_e5", dat[5], 16'hCAFE);
    chk16("l2_b2b_e8", dat[8], 16'hBEEF);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_asrt, n_fail);
    $finish;
  end

endmodule
